// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transfer sequencer.
package spi_seq_pkg;

    typedef enum logic [3:0] {
        IDLE, CLR, SEL, SSO_ON, WAIT_T, TX, WAIT_R, RX, SSO_OFF, DONE
    } state_e;

    // SPI core register map
    localparam logic [2:0] RXDATA   = 3'd0;
    localparam logic [2:0] TXDATA   = 3'd1;
    localparam logic [2:0] STATUS   = 3'd2;
    localparam logic [2:0] CONTROL  = 3'd3;
    localparam logic [2:0] SLAVESEL = 3'd5;

    localparam int          SSO_BIT  = 10;
    localparam logic [15:0] SSO_MASK = 16'h1 << SSO_BIT;
    localparam logic [4:0]  MAX_LEN  = 5'd16;

    // One register-port access as driven onto the bus
    typedef struct packed {
        logic        sel;
        logic        read_n;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } spi_acc_t;

    localparam spi_acc_t ACC_IDLE = '{sel: 1'b0, read_n: 1'b1, write_n: 1'b1,
                                      addr: 3'd0, wdata: 16'h0000};

    function automatic spi_acc_t acc_wr(input logic [2:0] addr, input logic [15:0] data);
        spi_acc_t a;
        a.sel     = 1'b1;
        a.read_n  = 1'b1;
        a.write_n = 1'b0;
        a.addr    = addr;
        a.wdata   = data;
        return a;
    endfunction

    function automatic spi_acc_t acc_rd(input logic [2:0] addr);
        spi_acc_t a;
        a.sel     = 1'b1;
        a.read_n  = 1'b0;
        a.write_n = 1'b1;
        a.addr    = addr;
        a.wdata   = 16'h0000;
        return a;
    endfunction

    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/spi_xfer_sequencer_if.sv
// Command / byte-stream / SPI register-port bundle of the sequencer.
// master = the sequencer, slave = its environment (command source, SPI core).
interface spi_xfer_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_slave;
    logic [4:0]  cmd_len;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        done;
    logic        spi_select;
    logic [2:0]  spi_addr;
    logic        spi_read_n;
    logic        spi_write_n;
    logic [15:0] spi_wdata;
    logic [15:0] spi_rdata;
    logic        spi_readyfordata;
    logic        spi_dataavailable;

    modport master (
        input  cmd_valid, cmd_slave, cmd_len, tx_data, tx_valid, rx_ready,
               spi_rdata, spi_readyfordata, spi_dataavailable,
        output cmd_ready, tx_ready, rx_data, rx_valid, busy, done,
               spi_select, spi_addr, spi_read_n, spi_write_n, spi_wdata
    );

    modport slave (
        output cmd_valid, cmd_slave, cmd_len, tx_data, tx_valid, rx_ready,
               spi_rdata, spi_readyfordata, spi_dataavailable,
        input  cmd_ready, tx_ready, rx_data, rx_valid, busy, done,
               spi_select, spi_addr, spi_read_n, spi_write_n, spi_wdata
    );
endinterface

// File: rtl/spi_seq_rxfifo.sv
// Circular RX byte buffer with a registered head word.
module spi_seq_rxfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_o
);
    import spi_seq_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q, rd_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             empty, do_pop, do_push;

    assign empty   = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty;
    // a pop frees the slot the same cycle, so push is allowed even when full
    assign do_push = push_i & (~full_o | do_pop);
    assign rd_d    = rd_q + PW'(do_pop);

    // Next head word: bypass the incoming byte when it lands on the new head slot
    always_comb begin
        head_d = mem_q[rd_d[AW-1:0]];
        if (do_push && (rd_d == wr_q)) head_d = wdata_i;
    end

    // Storage array write
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

    // Pointers and registered head; reset flushes the buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_q + PW'(do_push);
            rd_q   <= rd_d;
            head_q <= head_d;
        end
    end

    assign rdata_o = head_q;
    assign valid_o = ~empty;
endmodule

// File: rtl/spi_xfer_sequencer.sv
// Drives an SPI core's register port to run byte transfers for one command.
module spi_xfer_sequencer #(
    parameter int RX_DEPTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    spi_xfer_sequencer_if.master bus
);
    import spi_seq_pkg::*;

    state_e     state_q;
    logic [1:0] ph_q;      // access phase: 0,1 select high, 2 idle gap
    logic [4:0] cnt_q;     // bytes still to transfer
    logic [3:0] slave_q;
    spi_acc_t   acc_q;     // registered bus drive; TX byte is latched in its wdata
    logic       done_q;

    logic rx_full, rx_push, tx_fire;
    logic unused_rdata_hi;

    assign bus.tx_ready = (state_q == WAIT_T) & bus.spi_readyfordata & ~rx_full & ~reset;
    assign tx_fire      = bus.tx_ready & bus.tx_valid;
    assign rx_push      = (state_q == RX) && (ph_q == 2'd1);
    assign unused_rdata_hi = ^bus.spi_rdata[15:8];

    // Command sequencing; every access state runs the same 3-phase pattern
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ph_q    <= 2'd0;
            cnt_q   <= 5'd0;
            slave_q <= 4'd0;
            acc_q   <= ACC_IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    slave_q <= bus.cmd_slave;
                    cnt_q   <= clamp_len(bus.cmd_len);
                    if (bus.cmd_len == 5'd0) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= CLR;
                        acc_q   <= acc_wr(STATUS, 16'h0000);
                    end
                end
                WAIT_T: if (tx_fire) begin
                    state_q <= TX;
                    acc_q   <= acc_wr(TXDATA, {8'h00, bus.tx_data});
                end
                WAIT_R: if (bus.spi_dataavailable) begin
                    state_q <= RX;
                    acc_q   <= acc_rd(RXDATA);
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    case (ph_q)
                        2'd0: ph_q <= 2'd1;
                        2'd1: begin
                            ph_q  <= 2'd2;
                            acc_q <= ACC_IDLE;
                            if (state_q == RX) cnt_q <= cnt_q - 5'd1;
                        end
                        default: begin
                            ph_q <= 2'd0;
                            case (state_q)
                                CLR: begin
                                    state_q <= SEL;
                                    acc_q   <= acc_wr(SLAVESEL, 16'h1 << slave_q);
                                end
                                SEL: begin
                                    state_q <= SSO_ON;
                                    acc_q   <= acc_wr(CONTROL, SSO_MASK);
                                end
                                SSO_ON:  state_q <= WAIT_T;
                                TX:      state_q <= WAIT_R;
                                RX: begin
                                    if (cnt_q != 5'd0) begin
                                        state_q <= WAIT_T;
                                    end else begin
                                        state_q <= SSO_OFF;
                                        acc_q   <= acc_wr(CONTROL, 16'h0000);
                                    end
                                end
                                SSO_OFF: state_q <= DONE;
                                default: state_q <= IDLE;
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

    spi_seq_rxfifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rxfifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .wdata_i (bus.spi_rdata[7:0]),
        .pop_i   (bus.rx_ready),
        .rdata_o (bus.rx_data),
        .valid_o (bus.rx_valid),
        .full_o  (rx_full)
    );

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.spi_select  = acc_q.sel;
    assign bus.spi_read_n  = acc_q.read_n;
    assign bus.spi_write_n = acc_q.write_n;
    assign bus.spi_addr    = acc_q.addr;
    assign bus.spi_wdata   = acc_q.wdata;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench: scoreboarded SPI register accesses and RX bytes.
module tb_spi_xfer_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;

    spi_xfer_sequencer_if bus_if();
    spi_xfer_sequencer #(.RX_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus_if));

    always #5 clk = ~clk;

    typedef struct {
        bit        rd;
        bit [2:0]  addr;
        bit [15:0] wdata;
        int        len;
        bit        bad;
    } acc_t;

    acc_t       acc_obs_q[$];
    acc_t       acc_exp_q[$];
    logic [7:0] tx_src_q[$];
    logic [7:0] rx_exp_q[$];
    logic [7:0] rx_obs_q[$];
    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    acc_t       cur;
    bit         in_acc = 1'b0;
    logic       dav = 1'b0;

    // SPI core model: echoes each TX byte XOR 0x99, TRDY randomly stalls
    always @(posedge clk) begin
        bus_if.spi_readyfordata <= ($urandom_range(0, 3) != 0);
        if (reset) begin
            dav              <= 1'b0;
            bus_if.spi_rdata <= 16'h0000;
        end else if (bus_if.spi_select && !bus_if.spi_write_n && bus_if.spi_addr == 3'd1) begin
            bus_if.spi_rdata <= {8'h00, bus_if.spi_wdata[7:0] ^ 8'h99};
            dav              <= 1'b1;
        end else if (bus_if.spi_select && !bus_if.spi_read_n && bus_if.spi_addr == 3'd0) begin
            dav <= 1'b0;
        end
    end
    assign bus_if.spi_dataavailable = dav;

    // Bus monitor: logs accesses with their select length and stability, RX pops, done cycles
    always @(negedge clk) begin
        if (bus_if.done === 1'b1) done_cnt++;
        if (bus_if.rx_valid === 1'b1 && bus_if.rx_ready === 1'b1) rx_obs_q.push_back(bus_if.rx_data);
        if (bus_if.spi_select === 1'b1) begin
            if (!in_acc) begin
                in_acc    = 1'b1;
                cur.rd    = !bus_if.spi_read_n;
                cur.addr  = bus_if.spi_addr;
                cur.wdata = cur.rd ? 16'h0 : bus_if.spi_wdata;
                cur.len   = 1;
                cur.bad   = (bus_if.spi_read_n === bus_if.spi_write_n);
            end else begin
                cur.len++;
                if (bus_if.spi_read_n === bus_if.spi_write_n || cur.rd != !bus_if.spi_read_n ||
                    cur.addr != bus_if.spi_addr || (!cur.rd && cur.wdata != bus_if.spi_wdata))
                    cur.bad = 1'b1;
            end
        end else if (in_acc) begin
            in_acc = 1'b0;
            acc_obs_q.push_back(cur);
        end
    end

    // TX byte source fed from tx_src_q
    initial begin
        bit fire;
        forever begin
            @(negedge clk);
            fire = (bus_if.tx_valid === 1'b1) && (bus_if.tx_ready === 1'b1);
            @(posedge clk);
            #1;
            if (fire && tx_src_q.size() != 0) void'(tx_src_q.pop_front());
            if (tx_src_q.size() != 0) begin
                bus_if.tx_valid = 1'b1;
                bus_if.tx_data  = tx_src_q[0];
            end else begin
                bus_if.tx_valid = 1'b0;
                bus_if.tx_data  = 8'h00;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_acc(input bit rd, input bit [2:0] addr, input bit [15:0] wdata);
        acc_t a;
        a.rd = rd; a.addr = addr; a.wdata = wdata; a.len = 2; a.bad = 1'b0;
        acc_exp_q.push_back(a);
    endtask

    // Queue the expected bus sequence and bytes, then hand the command over
    task automatic send_cmd(input logic [3:0] slave, input logic [4:0] len,
                            input logic [7:0] first, input string tag);
        int n;
        int wc;
        logic [7:0] b;
        n  = (len > 5'd16) ? 16 : int'(len);
        wc = 0;
        if (n != 0) begin
            exp_acc(1'b0, 3'd2, 16'h0000);
            exp_acc(1'b0, 3'd5, 16'h1 << slave);
            exp_acc(1'b0, 3'd3, 16'h0400);
            for (int i = 0; i < n; i++) begin
                b = 8'(first + 8'(i * 37));
                tx_src_q.push_back(b);
                rx_exp_q.push_back(b ^ 8'h99);
                exp_acc(1'b0, 3'd1, {8'h00, b});
                exp_acc(1'b1, 3'd0, 16'h0000);
            end
            exp_acc(1'b0, 3'd3, 16'h0000);
        end
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_slave = slave;
        bus_if.cmd_len   = len;
        while (bus_if.cmd_ready !== 1'b1 && wc < 100) begin tick(); wc++; end
        chk({tag, " cmd_ready"}, 32'(bus_if.cmd_ready), 32'd1);
        tick();
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        int wc;
        start = done_cnt;
        wc    = 0;
        while (done_cnt == start && wc < budget) begin tick(); wc++; end
        repeat (3) tick();
        chk({tag, " done pulses"}, 32'(done_cnt - start), 32'd1);
    endtask

    task automatic check_acc(input string tag);
        acc_t e, o;
        while (acc_exp_q.size() != 0) begin
            e = acc_exp_q.pop_front();
            if (acc_obs_q.size() == 0) begin
                chk({tag, " access count"}, 32'(acc_obs_q.size()), 32'(acc_exp_q.size() + 1));
                acc_exp_q.delete();
                break;
            end
            o = acc_obs_q.pop_front();
            chk({tag, " access rd/addr/wdata"}, 32'({o.rd, o.addr, o.wdata}), 32'({e.rd, e.addr, e.wdata}));
            chk({tag, " select cycles"}, 32'(o.len), 32'(e.len));
            chk({tag, " strobe/addr stable"}, 32'(o.bad), 32'(e.bad));
        end
        chk({tag, " extra accesses"}, 32'(acc_obs_q.size()), 32'd0);
    endtask

    task automatic check_rx(input string tag);
        logic [7:0] e;
        while (rx_exp_q.size() != 0) begin
            e = rx_exp_q.pop_front();
            if (rx_obs_q.size() == 0) begin
                chk({tag, " rx count"}, 32'(rx_obs_q.size()), 32'(rx_exp_q.size() + 1));
                rx_exp_q.delete();
                break;
            end
            chk({tag, " rx byte"}, 32'(rx_obs_q.pop_front()), 32'(e));
        end
        chk({tag, " extra rx"}, 32'(rx_obs_q.size()), 32'd0);
    endtask

    initial begin
        int ntx;
        int seen;
        int wc;
        bit prev, cur_tx;

        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_slave = 4'd0;
        bus_if.cmd_len   = 5'd0;
        bus_if.rx_ready  = 1'b0;

        // reset values
        repeat (3) tick();
        chk("rst cmd_ready",   32'(bus_if.cmd_ready),   32'd1);
        chk("rst tx_ready",    32'(bus_if.tx_ready),    32'd0);
        chk("rst rx_valid",    32'(bus_if.rx_valid),    32'd0);
        chk("rst rx_data",     32'(bus_if.rx_data),     32'd0);
        chk("rst busy",        32'(bus_if.busy),        32'd0);
        chk("rst done",        32'(bus_if.done),        32'd0);
        chk("rst spi_select",  32'(bus_if.spi_select),  32'd0);
        chk("rst spi_read_n",  32'(bus_if.spi_read_n),  32'd1);
        chk("rst spi_write_n", 32'(bus_if.spi_write_n), 32'd1);
        chk("rst spi_addr",    32'(bus_if.spi_addr),    32'd0);
        chk("rst spi_wdata",   32'(bus_if.spi_wdata),   32'd0);
        reset = 1'b0;
        tick();

        // single byte, slave 3, 0xA5 echoed as 0x3C
        send_cmd(4'd3, 5'd1, 8'hA5, "single");
        wait_done("single", 500);
        check_acc("single");
        chk("single rx_valid", 32'(bus_if.rx_valid), 32'd1);
        chk("single rx_data",  32'(bus_if.rx_data),  32'h3C);
        bus_if.rx_ready = 1'b1;
        tick();
        bus_if.rx_ready = 1'b0;
        tick();
        chk("single rx drained", 32'(bus_if.rx_valid), 32'd0);
        check_rx("single");

        // zero length: no accesses, done two cycles after acceptance
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_slave = 4'd7;
        bus_if.cmd_len   = 5'd0;
        chk("zero cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
        tick();
        bus_if.cmd_valid = 1'b0;
        chk("zero busy +1",  32'(bus_if.busy), 32'd1);
        chk("zero done +1",  32'(bus_if.done), 32'd0);
        tick();
        chk("zero done +2",  32'(bus_if.done), 32'd1);
        chk("zero busy +2",  32'(bus_if.busy), 32'd0);
        tick();
        chk("zero done +3",  32'(bus_if.done), 32'd0);
        chk("zero no access", 32'(acc_obs_q.size()), 32'd0);

        // backpressure: 6 bytes into a 4-deep buffer that nobody drains
        bus_if.rx_ready = 1'b0;
        send_cmd(4'd9, 5'd6, 8'h10, "bp");
        repeat (150) tick();
        ntx = 0;
        foreach (acc_obs_q[i]) if (!acc_obs_q[i].rd && acc_obs_q[i].addr == 3'd1) ntx++;
        chk("bp tx writes while stalled", 32'(ntx), 32'd4);
        chk("bp busy while stalled",      32'(bus_if.busy), 32'd1);
        chk("bp tx bytes left",           32'(tx_src_q.size()), 32'd2);
        chk("bp tx_ready while full",     32'(bus_if.tx_ready), 32'd0);
        chk("bp rx_valid while full",     32'(bus_if.rx_valid), 32'd1);
        bus_if.rx_ready = 1'b1;
        wait_done("bp", 500);
        check_acc("bp");
        check_rx("bp");

        // len 31 clamps to 16 bytes; every access timing-checked; slave 15
        send_cmd(4'd15, 5'd31, 8'h5A, "len31");
        wait_done("len31", 3000);
        check_acc("len31");
        check_rx("len31");

        // reset in the second cycle of the second TX write
        bus_if.rx_ready = 1'b0;
        send_cmd(4'd1, 5'd4, 8'hC3, "rst");
        seen = 0; prev = 1'b0; wc = 0;
        while (seen < 2 && wc < 500) begin
            tick();
            wc++;
            cur_tx = (bus_if.spi_select === 1'b1) && (bus_if.spi_write_n === 1'b0) && (bus_if.spi_addr === 3'd1);
            if (cur_tx && !prev) seen++;
            prev = cur_tx;
        end
        chk("rst reached 2nd tx write", 32'(seen), 32'd2);
        tick();
        chk("rst 2nd select cycle", 32'(bus_if.spi_select), 32'd1);
        reset = 1'b1;
        tick();
        chk("rst abort spi_write_n", 32'(bus_if.spi_write_n), 32'd1);
        chk("rst abort spi_select",  32'(bus_if.spi_select),  32'd0);
        chk("rst abort rx_valid",    32'(bus_if.rx_valid),    32'd0);
        chk("rst abort rx_data",     32'(bus_if.rx_data),     32'd0);
        chk("rst abort cmd_ready",   32'(bus_if.cmd_ready),   32'd1);
        chk("rst abort busy",        32'(bus_if.busy),        32'd0);
        reset = 1'b0;
        repeat (2) tick();
        acc_obs_q.delete();
        acc_exp_q.delete();
        rx_exp_q.delete();
        rx_obs_q.delete();
        tx_src_q.delete();
        tick();

        bus_if.rx_ready = 1'b1;
        send_cmd(4'd0, 5'd2, 8'h77, "post-rst");
        wait_done("post-rst", 500);
        check_acc("post-rst");
        check_rx("post-rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
